hazard_unit_mc: RTL and testbench

- Next-generation hazard/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps the existing D- and E-stage forwarding and the load-use, branch and jr/jalr stalls.
- Adds sequential control for:
  - a multi-cycle divider in E;
  - data-memory wait states in M;
  - a precise exception flush from M;
  - a saturating stall-cycle performance counter.
- Register-address width and divider latency are parameters.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/div_stall_fsm.sv | 57 +++++
 rtl/hazard_unit_mc.sv | 108 ++++++++++
 tb/tb_hazard_unit_mc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_stall_fsm.sv
// Sequences a multi-cycle divide in E: holds E until the quotient is ready,
// then strobes divDone once. An M-stage exception abandons the divide.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic divE,
  input  logic exceptM,
  input  logic memwait,
  output logic divBusy,
  output logic divDone,
  output logic divStall
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  div_state_t      state;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else if (exceptM) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (divE && !memwait) begin
            state <= DIV_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        // The IDLE and DONE cycles bracket the BUSY run, so BUSY lasts DIV_CYCLES-2 cycles.
        DIV_BUSY: begin
          cnt <= cnt - CNT_LAST;
          if (cnt <= CNT_LAST) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (!memwait) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign divBusy  = (state != DIV_IDLE);
  assign divDone  = (state == DIV_DONE) && !memwait && !exceptM;
  assign divStall = divE && (state != DIV_DONE);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline: forwarding selects,
// prioritised stall/flush generation and a saturating stall-cycle counter.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              jalrD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              divE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              memreqM,
  input  logic              memackM,
  input  logic              exceptM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              div_busy,
  output logic              div_done,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic memwait, divStall, lwStall, branchStall, jrStall, baseD;

  // M wins over W because it holds the younger write to the same register.
  function automatic logic [1:0] fwdSelE(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] wrM, input logic weM,
                                         input logic [REG_AW-1:0] wrW, input logic weW);
    if (src != '0 && weM && src == wrM)      return FWD_M;
    else if (src != '0 && weW && src == wrW) return FWD_W;
    else                                     return FWD_RF;
  endfunction

  assign forwardaD = (rsD != '0) && regwriteM && (rsD == writeregM);
  assign forwardbD = (rtD != '0) && regwriteM && (rtD == writeregM);
  assign forwardaE = fwdSelE(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardbE = fwdSelE(rtE, writeregM, regwriteM, writeregW, regwriteW);

  assign lwStall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign branchStall = branchD &&
                       ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                        (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  assign jrStall     = (jrD || jalrD) && regwriteE && (writeregE == rsD);
  assign baseD       = lwStall || branchStall || jrStall;
  assign memwait     = memreqM && !memackM;

  div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .divE     (divE),
    .exceptM  (exceptM),
    .memwait  (memwait),
    .divBusy  (div_busy),
    .divDone  (div_done),
    .divStall (divStall)
  );

  always_comb begin
    stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
    flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
    if (resetn) begin
      // The exception flush lets the handler fetch proceed, so it drops every stall.
      if (exceptM) begin
        flushD = 1'b1; flushE = 1'b1; flushM = 1'b1; flushW = 1'b1;
      end else if (memwait) begin
        stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
        flushW = 1'b1;
      end else if (divStall) begin
        stallF = 1'b1; stallD = 1'b1; stallE = 1'b1;
        flushM = 1'b1;
      end else if (baseD) begin
        stallF = 1'b1; stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)                              stall_cnt <= '0;
    else if (stallF && (stall_cnt != '1))     stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_unit_mc;
  localparam int REG_AW     = 5;
  localparam int DIV_CYCLES = 4;
  localparam int CNT_W      = 3;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, jrD, jalrD, regwriteE, memtoregE, divE;
  logic regwriteM, memtoregM, memreqM, memackM, exceptM, regwriteW;
  logic forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic div_busy, div_done;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since the divide was accepted (0 = none) and the counter.
  int mAge = 0;
  int mCnt = 0;
  logic eStallF;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(REG_AW), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD), .jalrD(jalrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .divE(divE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .memreqM(memreqM), .memackM(memackM), .exceptM(exceptM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    resetn = 1'b1;
    rsD = '0; rtD = '0; rsE = '0; rtE = '0; writeregE = '0; writeregM = '0; writeregW = '0;
    branchD = 0; jrD = 0; jalrD = 0; regwriteE = 0; memtoregE = 0; divE = 0;
    regwriteM = 0; memtoregM = 0; memreqM = 0; memackM = 0; exceptM = 0; regwriteW = 0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] src);
    if (src == 0) return 2'b00;
    if (regwriteM && writeregM == src) return 2'b10;
    if (regwriteW && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs for the current inputs and model state; stalls are {F,D,E,M}, flushes {D,E,M,W}.
  task automatic check_outputs();
    logic mw, dstall, lw, br, jr, doneCyc;
    logic [3:0] eStall, eFlush;
    mw      = memreqM && !memackM;
    doneCyc = (mAge == DIV_CYCLES - 1);
    dstall  = divE && !doneCyc;
    lw = memtoregE && (rtE == rsD || rtE == rtD);
    br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                     (memtoregM && (writeregM == rsD || writeregM == rtD)));
    jr = (jrD || jalrD) && regwriteE && (writeregE == rsD);
    eStall = 4'b0000; eFlush = 4'b0000;
    if (!resetn)          begin eStall = 4'b0000; eFlush = 4'b0000; end
    else if (exceptM)     begin eStall = 4'b0000; eFlush = 4'b1111; end
    else if (mw)          begin eStall = 4'b1111; eFlush = 4'b0001; end
    else if (dstall)      begin eStall = 4'b1110; eFlush = 4'b0010; end
    else if (lw|br|jr)    begin eStall = 4'b1100; eFlush = 4'b0100; end
    eStallF = eStall[3];
    check("stalls",    {stallF, stallD, stallE, stallM}, eStall);
    check("flushes",   {flushD, flushE, flushM, flushW}, eFlush);
    check("forwardaD", forwardaD, (rsD != 0) && regwriteM && (writeregM == rsD));
    check("forwardbD", forwardbD, (rtD != 0) && regwriteM && (writeregM == rtD));
    check("forwardaE", forwardaE, ref_fwd(rsE));
    check("forwardbE", forwardbE, ref_fwd(rtE));
    check("div_busy",  div_busy, mAge != 0);
    check("div_done",  div_done, doneCyc && !mw && !exceptM);
    check("stall_cnt", stall_cnt, mCnt);
  endtask

  task automatic model_clock();
    logic mw;
    mw = memreqM && !memackM;
    if (!resetn) begin
      mAge = 0; mCnt = 0;
    end else begin
      if (eStallF && mCnt < CNT_MAX) mCnt++;
      if (exceptM)                       mAge = 0;
      else if (mAge == 0)                mAge = (divE && !mw) ? 1 : 0;
      else if (mAge < DIV_CYCLES - 1)    mAge++;
      else if (!mw)                      mAge = 0;
    end
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic cycle();
    #2;
    check_outputs();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
  endtask

  initial begin
    logic [2:0] expBusy, expDone, expStallE;
    clear_inputs();
    resetn = 1'b0;
    @(negedge clk);
    cycle();
    #1 check("reset_cnt", stall_cnt, 0);
    check("reset_busy", div_busy, 0);
    resetn = 1'b1;

    // Forwarding: M beats W, register 0 never forwards.
    rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    #1 check("fwd_m_priority", forwardaE, 2'b10);
    cycle();
    rsE = 0; writeregM = 0; regwriteM = 1;
    #1 check("fwd_reg0", forwardaE, 2'b00);
    cycle();
    clear_inputs();

    // Load-use stall for one cycle.
    do_reset();
    memtoregE = 1; rtE = 5; rsD = 5;
    #1 check("lw_stallF", stallF, 1);
    check("lw_flushE", flushE, 1);
    cycle();
    clear_inputs();
    #1 check("lw_cnt", stall_cnt, 1);
    cycle();

    // Divider, DIV_CYCLES=4: stall on cycles 0-2, done on cycle 3.
    do_reset();
    expBusy = 3'b111; expDone = 3'b100; expStallE = 3'b000;
    for (int i = 0; i < 4; i++) begin
      divE = 1;
      #1;
      if (i == 0) check("div_idle_busy", div_busy, 0);
      else        check("div_busy_run", div_busy, expBusy[i-1]);
      check("div_stallE", stallE, i < 3);
      check("div_flushM", flushM, i < 3);
      check("div_done_seq", div_done, i == 3);
      cycle();
    end
    divE = 0;
    #1 check("div_cnt3", stall_cnt, 3);
    check("div_back_idle", div_busy, 0);
    cycle();

    // Memory wait with a concurrent divide: the divide waits for the ack.
    do_reset();
    divE = 1; memreqM = 1; memackM = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("mw_stallM", stallM, 1);
      check("mw_flushW", flushW, 1);
      check("mw_div_held", div_busy, 0);
      cycle();
    end
    memackM = 1;
    #1 check("mw_ack_stallM", stallM, 0);
    check("mw_ack_stallE", stallE, 1);
    cycle();
    memreqM = 0; memackM = 0;
    #1 check("mw_div_started", div_busy, 1);
    for (int i = 0; i < 3; i++) cycle();
    clear_inputs();
    cycle();

    // Exception mid-division.
    do_reset();
    divE = 1;
    cycle(); cycle();
    exceptM = 1;
    #1 check("exc_flushW", flushW, 1);
    check("exc_stallF", stallF, 0);
    cycle();
    exceptM = 0; divE = 0;
    #1 check("exc_idle", div_busy, 0);
    for (int i = 0; i < 4; i++) cycle();

    // Reset during BUSY.
    do_reset();
    divE = 1;
    cycle(); cycle();
    resetn = 0;
    cycle();
    #1 check("rst_busy", div_busy, 0);
    check("rst_stallF", stallF, 0);
    check("rst_done", div_done, 0);
    cycle();
    clear_inputs();

    // Counter saturation.
    do_reset();
    memtoregE = 1; rtE = 7; rtD = 7;
    for (int i = 0; i < 10; i++) cycle();
    #1 check("cnt_sat", stall_cnt, CNT_MAX);
    clear_inputs();
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      resetn    = ($urandom_range(0, 40) != 0);
      rsD       = REG_AW'($urandom_range(0, 3));
      rtD       = REG_AW'($urandom_range(0, 3));
      rsE       = REG_AW'($urandom_range(0, 3));
      rtE       = REG_AW'($urandom_range(0, 3));
      writeregE = REG_AW'($urandom_range(0, 3));
      writeregM = REG_AW'($urandom_range(0, 3));
      writeregW = REG_AW'($urandom_range(0, 3));
      branchD   = $urandom_range(0, 3) == 0;
      jrD       = $urandom_range(0, 7) == 0;
      jalrD     = $urandom_range(0, 7) == 0;
      regwriteE = $urandom_range(0, 1);
      memtoregE = $urandom_range(0, 3) == 0;
      divE      = $urandom_range(0, 3) != 0;
      regwriteM = $urandom_range(0, 1);
      memtoregM = $urandom_range(0, 3) == 0;
      memreqM   = $urandom_range(0, 2) == 0;
      memackM   = $urandom_range(0, 1);
      exceptM   = $urandom_range(0, 19) == 0;
      regwriteW = $urandom_range(0, 1);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
